// File: rtl/cluster_decoder_if.sv
// rtl/cluster_decoder_if.sv - packed cluster word stream into the decoder
interface cluster_decoder_if;
   logic [13:0] clst_word;
   logic        clst_valid;
   logic        clst_sof;

   modport master (output clst_word, output clst_valid, output clst_sof);
   modport slave  (input  clst_word, input  clst_valid, input  clst_sof);
endinterface

// File: rtl/cluster_decoder.sv
// rtl/cluster_decoder.sv - rebuilds pad map, cluster count and flags from packed cluster words
module cluster_decoder #(
   parameter int          MXPADS       = 1536,
   parameter int          MXCLUSTERS   = 8,
   parameter logic [10:0] ADDR_INVALID = 11'h7FE
) (
   input  logic                clock4x,
   input  logic                reset,
   cluster_decoder_if.slave    clst,
   output logic [MXPADS-1:0]   vpfs_out,
   output logic [7:0]          cnt,
   output logic                overflow,
   output logic                frame_done,
   output logic                err_range,
   output logic                err_trunc
);

   typedef enum logic {IDLE, COLLECT} state_t;

   localparam int              IDX_W    = $clog2(MXCLUSTERS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MXCLUSTERS - 1);
   localparam logic [3:0]      CNT_MAX  = 4'(MXCLUSTERS);
   localparam logic [11:0]     PAD_LAST = 12'(MXPADS - 1);

   state_t              state, state_nx;
   logic [IDX_W-1:0]    idx, idx_nx;
   logic [MXPADS-1:0]   acc_map, acc_map_nx;
   logic [3:0]          acc_cnt, acc_cnt_nx;
   logic                acc_err, acc_err_nx;

   // Completed frame waits here one cycle so the outputs move on the edge after the last word
   logic                pend_valid, pend_valid_nx;
   logic [MXPADS-1:0]   pend_map, pend_map_nx;
   logic [3:0]          pend_cnt, pend_cnt_nx;
   logic                pend_err, pend_err_nx;
   logic                pend_trunc, pend_trunc_nx;

   logic [10:0]         addr;
   logic [2:0]          size;
   logic [11:0]         addr_end;
   logic                word_empty;
   logic                word_bad;
   logic [7:0]          run;
   logic [MXPADS-1:0]   word_mask;
   logic [MXPADS-1:0]   merge_map;
   logic [3:0]          merge_cnt;
   logic                merge_err;

   // Decode one cluster word into its pad mask; bits past the last pad fall off the shift
   always_comb begin
      addr       = clst.clst_word[13:3];
      size       = clst.clst_word[2:0];
      addr_end   = {1'b0, addr} + {9'b0, size};
      word_empty = (addr == ADDR_INVALID);
      word_bad   = !word_empty && (addr_end > PAD_LAST);
      run        = 8'hFF >> (3'd7 - size);
      word_mask  = '0;
      if (!word_empty)
         word_mask = {{(MXPADS-8){1'b0}}, run} << addr;
      merge_map  = acc_map | word_mask;
      merge_cnt  = (!word_empty && acc_cnt != CNT_MAX) ? acc_cnt + 4'd1 : acc_cnt;
      merge_err  = acc_err | word_bad;
   end

   // Frame FSM: next state, word index, accumulators and the completed-frame snapshot
   always_comb begin
      state_nx      = state;
      idx_nx        = idx;
      acc_map_nx    = acc_map;
      acc_cnt_nx    = acc_cnt;
      acc_err_nx    = acc_err;
      pend_valid_nx = 1'b0;
      pend_map_nx   = pend_map;
      pend_cnt_nx   = pend_cnt;
      pend_err_nx   = pend_err;
      pend_trunc_nx = pend_trunc;
      case (state)
         IDLE: begin
            if (clst.clst_valid && clst.clst_sof) begin
               acc_map_nx = word_mask;
               acc_cnt_nx = {3'b000, !word_empty};
               acc_err_nx = word_bad;
               idx_nx     = IDX_W'(1);
               state_nx   = COLLECT;
            end
         end
         COLLECT: begin
            if (clst.clst_valid) begin
               if (clst.clst_sof) begin
                  // Truncation: ship the partial frame and restart on this word
                  pend_valid_nx = 1'b1;
                  pend_map_nx   = acc_map;
                  pend_cnt_nx   = acc_cnt;
                  pend_err_nx   = acc_err;
                  pend_trunc_nx = 1'b1;
                  acc_map_nx    = word_mask;
                  acc_cnt_nx    = {3'b000, !word_empty};
                  acc_err_nx    = word_bad;
                  idx_nx        = IDX_W'(1);
               end else begin
                  acc_map_nx = merge_map;
                  acc_cnt_nx = merge_cnt;
                  acc_err_nx = merge_err;
                  if (idx == IDX_LAST) begin
                     pend_valid_nx = 1'b1;
                     pend_map_nx   = merge_map;
                     pend_cnt_nx   = merge_cnt;
                     pend_err_nx   = merge_err;
                     pend_trunc_nx = 1'b0;
                     idx_nx        = '0;
                     state_nx      = IDLE;
                  end else begin
                     idx_nx = idx + IDX_W'(1);
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, accumulators and output registers; outputs load only when a frame completes
   always_ff @(posedge clock4x) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         acc_map    <= '0;
         acc_cnt    <= '0;
         acc_err    <= 1'b0;
         pend_valid <= 1'b0;
         pend_map   <= '0;
         pend_cnt   <= '0;
         pend_err   <= 1'b0;
         pend_trunc <= 1'b0;
         vpfs_out   <= '0;
         cnt        <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
         err_range  <= 1'b0;
         err_trunc  <= 1'b0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         acc_map    <= acc_map_nx;
         acc_cnt    <= acc_cnt_nx;
         acc_err    <= acc_err_nx;
         pend_valid <= pend_valid_nx;
         pend_map   <= pend_map_nx;
         pend_cnt   <= pend_cnt_nx;
         pend_err   <= pend_err_nx;
         pend_trunc <= pend_trunc_nx;
         frame_done <= pend_valid;
         if (pend_valid) begin
            vpfs_out  <= pend_map;
            cnt       <= {4'b0000, pend_cnt};
            overflow  <= (pend_cnt == CNT_MAX);
            err_range <= pend_err;
            err_trunc <= pend_trunc;
         end
      end
   end

endmodule

// File: tb/tb_cluster_decoder.sv
// tb/tb_cluster_decoder.sv - scoreboard bench for cluster_decoder
`timescale 1ns/1ps
module tb_cluster_decoder;

   localparam logic [10:0] INV = 11'h7FE;

   typedef struct {
      logic [1535:0] map;
      int            cnt;
      logic          ovf;
      logic          er;
      logic          et;
      int            cyc;
   } exp_t;

   logic           clock4x = 1'b0;
   logic           reset;
   logic [1535:0]  vpfs_out;
   logic [7:0]     cnt;
   logic           overflow, frame_done, err_range, err_trunc;

   int             n_chk  = 0;
   int             n_fail = 0;
   int             cyc    = 0;
   int             last_cyc;
   exp_t           sbq[$];
   logic [1535:0]  m4b;

   cluster_decoder_if clst_if ();

   cluster_decoder dut (
      .clock4x    (clock4x),
      .reset      (reset),
      .clst       (clst_if.slave),
      .vpfs_out   (vpfs_out),
      .cnt        (cnt),
      .overflow   (overflow),
      .frame_done (frame_done),
      .err_range  (err_range),
      .err_trunc  (err_trunc)
   );

   always #5 clock4x = ~clock4x;

   always @(posedge clock4x) cyc <= cyc + 1;

   function automatic logic [1535:0] bits(input logic [1535:0] m, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic chk(input string nm, input longint act, input longint req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic chk_map(input string nm, input logic [1535:0] act, input logic [1535:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual_popcount=%0d required_popcount=%0d", nm, $countones(act), $countones(req));
      end
   endtask

   task automatic send(input logic [10:0] a, input logic [2:0] s, input logic sof);
      clst_if.clst_word  = {a, s};
      clst_if.clst_valid = 1'b1;
      clst_if.clst_sof   = sof;
      last_cyc = cyc;
      @(posedge clock4x);
      #1;
      clst_if.clst_valid = 1'b0;
      clst_if.clst_sof   = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge clock4x);
         #1;
      end
   endtask

   task automatic push(input logic [1535:0] m, input int c, input logic ovf, input logic er, input logic et);
      exp_t e;
      e.map = m; e.cnt = c; e.ovf = ovf; e.er = er; e.et = et; e.cyc = last_cyc + 2;
      sbq.push_back(e);
   endtask

   // Monitor: every frame_done pulse must match the oldest expected frame
   always @(negedge clock4x) begin
      if (!reset && frame_done) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_frame_done actual=1 required=0 at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk_map("vpfs_out", vpfs_out, e.map);
            chk("cnt", longint'(cnt), longint'(e.cnt));
            chk("overflow", longint'(overflow), longint'(e.ovf));
            chk("err_range", longint'(err_range), longint'(e.er));
            chk("err_trunc", longint'(err_trunc), longint'(e.et));
            chk("done_cycle", longint'(cyc), longint'(e.cyc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [1535:0] m;
      reset = 1'b1;
      clst_if.clst_word  = '0;
      clst_if.clst_valid = 1'b0;
      clst_if.clst_sof   = 1'b0;
      gap(2);
      chk_map("reset_vpfs", vpfs_out, '0);
      chk("reset_cnt", longint'(cnt), 0);
      chk("reset_done", longint'(frame_done), 0);
      chk("reset_flags", longint'({overflow, err_range, err_trunc}), 0);

      // Frame 1: three clusters and five empty slots, sof right after reset release
      reset = 1'b0;
      send(11'd0, 3'd0, 1'b1);
      send(11'd5, 3'd2, 1'b0);
      send(11'd1535, 3'd0, 1'b0);
      for (int i = 0; i < 5; i++) send(INV, 3'd0, 1'b0);
      m = bits('0, 0, 0); m = bits(m, 5, 7); m = bits(m, 1535, 1535);
      push(m, 3, 1'b0, 1'b0, 1'b0);
      gap(3);

      // Frame 2: eight full clusters with two-cycle gaps
      m = '0;
      for (int k = 0; k < 8; k++) begin
         send(11'(10 * k), 3'd7, k == 0);
         m = bits(m, 10 * k, 10 * k + 7);
         if (k < 7) gap(2);
      end
      push(m, 8, 1'b1, 1'b0, 1'b0);
      gap(3);

      // Frame 3: clipped cluster and out-of-range address
      send(11'd1534, 3'd7, 1'b1);
      send(11'd1600, 3'd0, 1'b0);
      for (int i = 0; i < 6; i++) send(INV, 3'd0, 1'b0);
      push(bits('0, 1534, 1535), 2, 1'b0, 1'b1, 1'b0);
      gap(3);

      // Frame 4: truncated after three words, then a clean frame
      send(11'd100, 3'd1, 1'b1);
      send(11'd200, 3'd0, 1'b0);
      send(11'd300, 3'd3, 1'b0);
      send(11'd7, 3'd0, 1'b1);
      m = bits('0, 100, 101); m = bits(m, 200, 200); m = bits(m, 300, 303);
      push(m, 3, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) send(INV, 3'd0, 1'b0);
      m4b = bits('0, 7, 7);
      push(m4b, 1, 1'b0, 1'b0, 1'b0);
      gap(4);

      // Words in IDLE without sof are ignored
      for (int i = 0; i < 3; i++) send(11'd50, 3'd0, 1'b0);
      gap(4);
      chk_map("idle_hold_vpfs", vpfs_out, m4b);
      chk("idle_hold_cnt", longint'(cnt), 1);
      chk("idle_hold_trunc", longint'(err_trunc), 0);
      chk("idle_queue", longint'(sbq.size()), 0);

      // Reset mid-frame discards the partial frame
      send(11'd20, 3'd0, 1'b1);
      send(11'd21, 3'd0, 1'b0);
      send(11'd22, 3'd0, 1'b0);
      send(11'd23, 3'd0, 1'b0);
      reset = 1'b1;
      gap(1);
      reset = 1'b0;
      chk_map("midreset_vpfs", vpfs_out, '0);
      chk("midreset_cnt", longint'(cnt), 0);
      chk("midreset_done", longint'(frame_done), 0);

      // Fresh frame after reset
      send(11'd1000, 3'd3, 1'b1);
      for (int i = 0; i < 7; i++) send(INV, 3'd0, 1'b0);
      push(bits('0, 1000, 1003), 1, 1'b0, 1'b0, 1'b0);
      gap(6);

      chk("final_queue_empty", longint'(sbq.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
